weight_fetch_ctrl: RTL and testbench

Sequencer that streams a contiguous block of weight words out of the synchronous weight memory, mem_cell, to the compute datapath. It drives the memory's addr/r_en, absorbs the 1-cycle read latency and converts memory output into a valid/ready stream with full backpressure, using an internal 2-entry buffer. One command (base address + word count) per transfer; completion is signalled with a done pulse.

---
 rtl/weight_fetch_ctrl_pkg.sv | 18 +
 rtl/weight_fetch_ctrl_fetch_skid_buf.sv | 61 ++++++
 rtl/weight_fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_fetch_ctrl_pkg.sv
// Shared definitions for the weight fetch sequencer: FSM encodings and buffer depth.
package weight_fetch_ctrl_pkg;

  // FSM state encodings (kept as plain constants for legacy tool compatibility)
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Output buffer depth; two entries absorb the one-cycle read latency at full rate
  localparam int unsigned FETCH_BUF_DEPTH = 2;

  // A command is in progress in every state except idle
  function automatic logic state_is_busy(input logic [1:0] state);
    return state != StIdle;
  endfunction

endpackage

// File: rtl/weight_fetch_ctrl_fetch_skid_buf.sv
// Two-entry synchronous FIFO holding {last, data} words returned from the weight memory.
module fetch_skid_buf
  import weight_fetch_ctrl_pkg::*;
#(
  parameter int unsigned Width = 65
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [FETCH_BUF_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             do_push;
  logic             do_pop;

  // Pop frees space first, so a push into a full buffer is legal alongside a pop
  always_comb begin
    do_pop  = pop_i & (count_q != 2'd0);
    do_push = push_i & ((count_q != 2'd2) | do_pop);
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 2'd1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 2'd1;
    end
    full_o  = (count_q == 2'd2);
    empty_o = (count_q == 2'd0);
    data_o  = mem_q[rd_ptr_q];
  end

  // Storage and pointers; single-bit pointers wrap naturally over the two entries
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FETCH_BUF_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight fetch sequencer: reads a contiguous block from the weight memory and streams it
// out over valid/ready, absorbing the memory's one-cycle read latency.
module weight_fetch_ctrl
  import weight_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_OUT_WIDTH = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [ADDR_WIDTH-1:0]     base_addr_i,
  input  logic [ADDR_WIDTH:0]       num_words_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic                      mem_r_en_o,
  input  logic [DATA_OUT_WIDTH-1:0] mem_data_i,
  output logic [DATA_OUT_WIDTH-1:0] w_data_o,
  output logic                      w_valid_o,
  input  logic                      w_ready_i,
  output logic                      w_last_o
);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   num_q, num_d;
  logic [ADDR_WIDTH:0]   issued_q, issued_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;

  logic                      buf_full;
  logic                      buf_empty;
  logic                      buf_valid;
  logic [DATA_OUT_WIDTH:0]   buf_head;
  logic                      head_last;
  logic                      pop;
  logic [2:0]                occupancy;
  logic [2:0]                need;
  logic                      issue;
  logic                      last_issue;

  // Issue decision: count buffered words plus the word in flight, minus one leaving now
  always_comb begin
    buf_valid  = ~buf_empty;
    head_last  = buf_head[DATA_OUT_WIDTH];
    pop        = buf_valid & w_ready_i;
    occupancy  = buf_full ? 3'd2 : (buf_empty ? 3'd0 : 3'd1);
    need       = occupancy + {2'b00, inflight_q} - {2'b00, pop};
    issue      = (state_q == StFetch) && (issued_q != num_q) && (need < 3'd2);
    last_issue = (issued_q + {{ADDR_WIDTH{1'b0}}, 1'b1}) == num_q;
  end

  // Next-state logic for the FSM, address and issue counters
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    num_d           = num_q;
    issued_d        = issued_q;
    inflight_d      = issue;
    inflight_last_d = issue & last_issue;
    if (issue) begin
      addr_d   = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      issued_d = issued_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d   = base_addr_i;
          num_d    = num_words_i;
          issued_d = '0;
          state_d  = (num_words_i == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (issue && last_issue) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && head_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Controller state; reset also discards any read still in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      num_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      num_q           <= num_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  fetch_skid_buf #(
    .Width (DATA_OUT_WIDTH + 1)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (inflight_q),
    .data_i  ({inflight_last_q, mem_data_i}),
    .pop_i   (pop),
    .data_o  (buf_head),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  // Outputs; stream data is zeroed when nothing is valid so idle outputs stay clean
  always_comb begin
    busy_o     = state_is_busy(state_q);
    done_o     = (state_q == StDone);
    mem_addr_o = addr_q;
    mem_r_en_o = issue;
    w_valid_o  = buf_valid;
    w_data_o   = buf_valid ? buf_head[DATA_OUT_WIDTH-1:0] : '0;
    w_last_o   = buf_valid & head_last;
  end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Self-checking bench for weight_fetch_ctrl with a behavioural weight memory and scoreboard.
module tb_weight_fetch_ctrl;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 64;

  logic          clk;
  logic          rst_ni;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_r_en;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] w_data;
  logic          w_valid;
  logic          w_ready;
  logic          w_last;

  logic [DW-1:0] mem [1024];
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] exp_addr[$];

  int n_vec;
  int n_err;
  int done_cnt;
  int last_cnt;
  int rdy_mode;
  int hold_lo;

  weight_fetch_ctrl #(
    .ADDR_WIDTH     (AW),
    .DATA_OUT_WIDTH (DW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start),
    .base_addr_i (base_addr),
    .num_words_i (num_words),
    .busy_o      (busy),
    .done_o      (done),
    .mem_addr_o  (mem_addr),
    .mem_r_en_o  (mem_r_en),
    .mem_data_i  (mem_data),
    .w_data_o    (w_data),
    .w_valid_o   (w_valid),
    .w_ready_i   (w_ready),
    .w_last_o    (w_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: one-cycle read latency
  always @(posedge clk) begin
    if (mem_r_en) mem_data <= mem[mem_addr];
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive a command at the current time and load the scoreboard with its expectations
  task automatic start_cmd(input logic [AW-1:0] b, input int n);
    logic [AW-1:0] a;
    base_addr = b;
    num_words = (AW+1)'(n);
    start     = 1'b1;
    done_cnt  = 0;
    last_cnt  = 0;
    for (int k = 0; k < n; k++) begin
      a = b + AW'(k);
      exp_addr.push_back(a);
      exp_q.push_back({(k == n - 1), mem[a]});
    end
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check_val("done_timeout", 64'(seen), 64'd1);
  endtask

  task automatic post_check(input int exp_last);
    repeat (2) @(negedge clk);
    check_val("done_cnt", 64'(done_cnt), 64'd1);
    check_val("last_cnt", 64'(last_cnt), 64'(exp_last));
    check_val("sb_left", 64'(exp_q.size()), 64'd0);
    check_val("addr_left", 64'(exp_addr.size()), 64'd0);
    check_val("idle_busy", 64'(busy), 64'd0);
  endtask

  // Consumer ready: 0 = always ready, 1 = random, 3 = never ready; hold_lo forces stalls
  initial begin
    w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_lo > 0) begin
        w_ready = 1'b0;
        hold_lo--;
      end else if (rdy_mode == 1) begin
        w_ready = 1'($urandom_range(0, 1));
      end else if (rdy_mode == 3) begin
        w_ready = 1'b0;
      end else begin
        w_ready = 1'b1;
      end
    end
  end

  // Monitor: address order, occupancy bound, hold stability and scoreboard data
  initial begin
    int iss;
    int popc;
    bit pop;
    bit stall_q;
    logic [DW-1:0] stall_d;
    logic stall_l;
    logic [DW:0] e;
    logic [AW-1:0] a;
    iss = 0;
    popc = 0;
    stall_q = 1'b0;
    stall_d = '0;
    stall_l = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        iss = 0;
        popc = 0;
        stall_q = 1'b0;
      end else begin
        pop = w_valid & w_ready;
        if (mem_r_en) begin
          check_val("occupancy", 64'((iss - popc + 1 - int'(pop)) <= 2), 64'd1);
          if (exp_addr.size() == 0) begin
            check_val("addr_extra", 64'd1, 64'd0);
          end else begin
            a = exp_addr.pop_front();
            check_val("addr", 64'(mem_addr), 64'(a));
          end
        end
        if (stall_q) begin
          check_val("hold_valid", 64'(w_valid), 64'd1);
          check_val("hold_data", w_data, stall_d);
          check_val("hold_last", 64'(w_last), 64'(stall_l));
        end
        if (pop) begin
          if (w_last) last_cnt++;
          if (exp_q.size() == 0) begin
            check_val("word_extra", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check_val("w_data", w_data, e[DW-1:0]);
            check_val("w_last", 64'(w_last), 64'(e[DW]));
          end
        end
        if (done) done_cnt++;
        iss += int'(mem_r_en);
        popc += int'(pop);
        stall_q = w_valid & ~w_ready;
        stall_d = w_data;
        stall_l = w_last;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    done_cnt = 0;
    last_cnt = 0;
    rdy_mode = 0;
    hold_lo = 0;
    start = 1'b0;
    base_addr = '0;
    num_words = '0;
    mem_data = '0;
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #12;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_ren", 64'(mem_r_en), 64'd0);
    check_val("rst_addr", 64'(mem_addr), 64'd0);
    check_val("rst_valid", 64'(w_valid), 64'd0);
    check_val("rst_last", 64'(w_last), 64'd0);
    check_val("rst_data", w_data, 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Basic: cycle-accurate latency and throughput
    @(posedge clk); #1;
    start_cmd(10'h010, 4);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check_val($sformatf("basic_ren_c%0d", c), 64'(mem_r_en), 64'(c >= 1 && c <= 4));
      check_val($sformatf("basic_valid_c%0d", c), 64'(w_valid), 64'(c >= 3 && c <= 6));
      check_val($sformatf("basic_last_c%0d", c), 64'(w_last), 64'(c == 6));
      check_val($sformatf("basic_done_c%0d", c), 64'(done), 64'(c == 7));
      check_val($sformatf("basic_busy_c%0d", c), 64'(busy), 64'(c <= 7));
    end
    post_check(1);

    // Backpressure: random ready plus a five-cycle hard stall
    rdy_mode = 1;
    @(posedge clk); #1;
    start_cmd(10'h040, 8);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    hold_lo = 5;
    wait_done(300);
    post_check(1);
    rdy_mode = 0;

    // Address wrap
    @(posedge clk); #1;
    start_cmd(10'h3FE, 4);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50);
    post_check(1);

    // Zero length
    @(posedge clk); #1;
    start_cmd(10'h123, 0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check_val($sformatf("zero_done_c%0d", c), 64'(done), 64'(c == 1));
      check_val($sformatf("zero_busy_c%0d", c), 64'(busy), 64'(c == 1));
      check_val($sformatf("zero_ren_c%0d", c), 64'(mem_r_en), 64'd0);
      check_val($sformatf("zero_valid_c%0d", c), 64'(w_valid), 64'd0);
    end
    post_check(0);

    // Start while busy: in FETCH and again during the DONE cycle
    @(posedge clk); #1;
    start_cmd(10'h100, 3);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    base_addr = 10'h300;
    num_words = 11'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val("ignored_busy", 64'(busy), 64'd0);
    end
    post_check(1);

    // Reset mid-transfer with one word buffered and one in flight
    rdy_mode = 3;
    @(posedge clk); #1;
    start_cmd(10'h080, 8);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("pre_rst_valid", 64'(w_valid), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    check_val("mid_rst_busy", 64'(busy), 64'd0);
    check_val("mid_rst_ren", 64'(mem_r_en), 64'd0);
    check_val("mid_rst_addr", 64'(mem_addr), 64'd0);
    check_val("mid_rst_valid", 64'(w_valid), 64'd0);
    check_val("mid_rst_last", 64'(w_last), 64'd0);
    check_val("mid_rst_data", w_data, 64'd0);
    exp_q.delete();
    exp_addr.delete();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val("post_rst_valid", 64'(w_valid), 64'd0);
    end
    @(posedge clk); #1;
    start_cmd(10'h200, 3);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50);
    post_check(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
